// File: rtl/td4_exec.sv
// Execute stage of the TD4 4-bit CPU.
// Decodes the instruction fetched for the current counter value and executes it
// in a single clock: one 4-bit adder feeds A, B or OUT, its carry-out always
// lands in C, and JMP/JNC steer the upstream counter through pc_load/pc_data.
module td4_exec #(
  parameter logic [3:0] OUT_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,     // asynchronous, active low
  input  logic [3:0] pc,
  output logic [3:0] rom_addr,
  input  logic [7:0] instr,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       pc_load,
  output logic [3:0] pc_data,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry
);

  // Opcodes
  localparam logic [3:0] OpAddA  = 4'b0000;
  localparam logic [3:0] OpMovAB = 4'b0001;
  localparam logic [3:0] OpInA   = 4'b0010;
  localparam logic [3:0] OpMovAI = 4'b0011;
  localparam logic [3:0] OpMovBA = 4'b0100;
  localparam logic [3:0] OpAddB  = 4'b0101;
  localparam logic [3:0] OpInB   = 4'b0110;
  localparam logic [3:0] OpMovBI = 4'b0111;
  localparam logic [3:0] OpOutB  = 4'b1001;
  localparam logic [3:0] OpOutI  = 4'b1011;
  localparam logic [3:0] OpJnc   = 4'b1110;
  localparam logic [3:0] OpJmp   = 4'b1111;

  // Adder source operand select
  localparam logic [1:0] SrcZero = 2'd0;
  localparam logic [1:0] SrcA    = 2'd1;
  localparam logic [1:0] SrcB    = 2'd2;
  localparam logic [1:0] SrcIn   = 2'd3;

  // Writeback destination select
  localparam logic [1:0] DstNone = 2'd0;
  localparam logic [1:0] DstA    = 2'd1;
  localparam logic [1:0] DstB    = 2'd2;
  localparam logic [1:0] DstOut  = 2'd3;

  logic [3:0] opcode;
  logic [3:0] imm;

  logic [1:0] src_sel;
  logic [1:0] dst_sel;
  logic       use_imm;
  logic       is_jmp;
  logic       is_jnc;

  logic [3:0] src_val;
  logic [3:0] imm_term;
  logic [4:0] sum;

  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       c_q, c_d;

  assign opcode = instr[7:4];
  assign imm    = instr[3:0];

  // Instruction decode into adder operand, writeback target and jump kind
  always_comb begin
    src_sel = SrcZero;
    dst_sel = DstNone;
    use_imm = 1'b0;
    is_jmp  = 1'b0;
    is_jnc  = 1'b0;
    case (opcode)
      OpAddA:  begin src_sel = SrcA;    use_imm = 1'b1; dst_sel = DstA;   end
      OpAddB:  begin src_sel = SrcB;    use_imm = 1'b1; dst_sel = DstB;   end
      OpMovAI: begin src_sel = SrcZero; use_imm = 1'b1; dst_sel = DstA;   end
      OpMovBI: begin src_sel = SrcZero; use_imm = 1'b1; dst_sel = DstB;   end
      OpMovAB: begin src_sel = SrcB;                    dst_sel = DstA;   end
      OpMovBA: begin src_sel = SrcA;                    dst_sel = DstB;   end
      OpInA:   begin src_sel = SrcIn;                   dst_sel = DstA;   end
      OpInB:   begin src_sel = SrcIn;                   dst_sel = DstB;   end
      OpOutB:  begin src_sel = SrcB;                    dst_sel = DstOut; end
      OpOutI:  begin src_sel = SrcZero; use_imm = 1'b1; dst_sel = DstOut; end
      OpJmp:   is_jmp = 1'b1;
      OpJnc:   is_jnc = 1'b1;
      default: ;
    endcase
  end

  // Shared adder; every non-ADD operation has a zero on one side so it can't carry
  always_comb begin
    src_val = 4'h0;
    case (src_sel)
      SrcA:    src_val = a_q;
      SrcB:    src_val = b_q;
      SrcIn:   src_val = in_port;
      default: src_val = 4'h0;
    endcase
    imm_term = use_imm ? imm : 4'h0;
    sum      = {1'b0, src_val} + {1'b0, imm_term};
  end

  // Writeback of the adder result; C follows the carry-out on every instruction
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    c_d   = sum[4];
    case (dst_sel)
      DstA:    a_d   = sum[3:0];
      DstB:    b_d   = sum[3:0];
      DstOut:  out_d = sum[3:0];
      default: ;
    endcase
  end

  // Architectural state; reset is asynchronous and shared with the counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= 4'h0;
      b_q   <= 4'h0;
      out_q <= OUT_RESET;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      c_q   <= c_d;
    end
  end

  // JNC tests the carry produced by the previous instruction (c_q, pre-edge)
  assign pc_load  = reset & (is_jmp | (is_jnc & ~c_q));
  assign pc_data  = imm;
  assign rom_addr = pc;

  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign carry    = c_q;

endmodule

// File: tb/tb_td4_exec.sv
// Bench for td4_exec: a program counter model closes the jump loop, and a
// behavioural ISA model predicts A, B, OUT, C, the jump request and the fetch address.
module tb_td4_exec;

  logic       clk;
  logic       reset;
  logic [3:0] pc;
  logic [3:0] rom_addr;
  logic [7:0] instr;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic       pc_load;
  logic [3:0] pc_data;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       carry;

  int n_vec;
  int n_err;

  // ISA model state
  logic [3:0] m_a, m_b, m_out, exp_pc;
  logic       m_c;

  // Pre-edge observations and predictions of the most recent exec
  logic       obs_load, exp_load;
  logic [3:0] obs_data, exp_data, obs_addr, exp_addr;

  logic [7:0] rom [16];

  td4_exec #(.OUT_RESET(4'b0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .rom_addr (rom_addr),
    .instr    (instr),
    .in_port  (in_port),
    .out_port (out_port),
    .pc_load  (pc_load),
    .pc_data  (pc_data),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream program counter sharing the reset net
  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 4'd0;
    else if (pc_load) pc <= pc_data;
    else pc <= pc + 4'd1;
  end

  task automatic model_reset();
    m_a = 4'h0; m_b = 4'h0; m_out = 4'h0; m_c = 1'b0; exp_pc = 4'h0;
  endtask

  // Apply one instruction for one clock and advance the ISA model
  task automatic exec(input logic [7:0] ins, input logic [3:0] inp);
    logic [3:0] op;
    logic [3:0] im;
    logic [4:0] s;
    op = ins[7:4];
    im = ins[3:0];
    instr   = ins;
    in_port = inp;
    #1;
    obs_load = pc_load;
    obs_data = pc_data;
    obs_addr = rom_addr;
    exp_load = (op == 4'hF) || (op == 4'hE && !m_c);
    exp_data = im;
    exp_addr = exp_pc;
    @(posedge clk);
    #1;
    s = 5'd0;
    case (op)
      4'h0: begin s = {1'b0, m_a} + {1'b0, im}; m_a = s[3:0]; end
      4'h5: begin s = {1'b0, m_b} + {1'b0, im}; m_b = s[3:0]; end
      4'h3: m_a = im;
      4'h7: m_b = im;
      4'h1: m_a = m_b;
      4'h4: m_b = m_a;
      4'h2: m_a = inp;
      4'h6: m_b = inp;
      4'h9: m_out = m_b;
      4'hB: m_out = im;
      default: ;
    endcase
    m_c = s[4];
    exp_pc = exp_load ? im : exp_pc + 4'd1;
  endtask

  // Pulse reset for one edge and leave it released just after a rising edge
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    instr = 8'hF0;
    #1;
    n_vec++;
    if ({reg_a, reg_b, out_port, carry} !== 13'h0) begin
      n_err++; $display("FAIL reset_init: got %h expected %h", {reg_a, reg_b, out_port, carry}, 13'h0);
    end
    n_vec++;
    if (pc_load !== 1'b0) begin
      n_err++; $display("FAIL reset_init_load: got %b expected %b", pc_load, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    exec(8'h73, 4'h0);
    exec(8'hB9, 4'h0);
    exec(8'h3F, 4'h0);
    exec(8'h06, 4'h0);
    n_vec++;
    if ({reg_a, reg_b, out_port, carry} !== {4'h5, 4'h3, 4'h9, 1'b1}) begin
      n_err++; $display("FAIL reset_preload: got %h expected %h",
                        {reg_a, reg_b, out_port, carry}, {4'h5, 4'h3, 4'h9, 1'b1});
    end
    // Assert reset between edges with a JMP on the bus
    instr = 8'hF0;
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({reg_a, reg_b, out_port, carry} !== 13'h0) begin
      n_err++; $display("FAIL reset_async: got %h expected %h", {reg_a, reg_b, out_port, carry}, 13'h0);
    end
    n_vec++;
    if (pc_load !== 1'b0) begin
      n_err++; $display("FAIL reset_async_load: got %b expected %b", pc_load, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_alu();
    exec(8'h33, 4'h0);
    exec(8'h04, 4'h0);
    exec(8'h40, 4'h0);
    exec(8'h90, 4'h0);
    n_vec++;
    if ({reg_a, reg_b, out_port, carry} !== {4'h7, 4'h7, 4'h7, 1'b0}) begin
      n_err++; $display("FAIL alu_seq: got %h expected %h",
                        {reg_a, reg_b, out_port, carry}, {4'h7, 4'h7, 4'h7, 1'b0});
    end
  endtask

  task automatic test_jnc_not_taken();
    exec(8'h3F, 4'h0);
    exec(8'h01, 4'h0);
    n_vec++;
    if ({reg_a, carry} !== {4'h0, 1'b1}) begin
      n_err++; $display("FAIL add_carry: got %h expected %h", {reg_a, carry}, {4'h0, 1'b1});
    end
    exec(8'hE5, 4'h0);
    n_vec++;
    if (obs_load !== 1'b0) begin
      n_err++; $display("FAIL jnc_not_taken_load: got %b expected %b", obs_load, 1'b0);
    end
    n_vec++;
    if (carry !== 1'b0) begin
      n_err++; $display("FAIL jnc_clears_c: got %b expected %b", carry, 1'b0);
    end
  endtask

  task automatic test_jnc_taken();
    exec(8'hE5, 4'h0);
    n_vec++;
    if ({obs_load, obs_data} !== {1'b1, 4'h5}) begin
      n_err++; $display("FAIL jnc_taken: got %h expected %h", {obs_load, obs_data}, {1'b1, 4'h5});
    end
    n_vec++;
    if (rom_addr !== 4'h5) begin
      n_err++; $display("FAIL jnc_target_addr: got %h expected %h", rom_addr, 4'h5);
    end
  endtask

  task automatic test_loop();
    logic [3:0] k4;
    pulse_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h51;
    rom[1] = 8'h90;
    rom[2] = 8'hF0;
    for (int it = 1; it <= 16; it++) begin
      k4 = it[3:0];
      exec(rom[pc], 4'h0);
      n_vec++;
      if ({obs_addr, carry} !== {4'h0, (it == 16)}) begin
        n_err++; $display("FAIL loop_add it=%0d: got %h expected %h", it, {obs_addr, carry},
                          {4'h0, (it == 16)});
      end
      exec(rom[pc], 4'h0);
      n_vec++;
      if ({out_port, carry} !== {k4, 1'b0}) begin
        n_err++; $display("FAIL loop_out it=%0d: got %h expected %h", it, {out_port, carry}, {k4, 1'b0});
      end
      exec(rom[pc], 4'h0);
      n_vec++;
      if ({obs_load, rom_addr} !== {1'b1, 4'h0}) begin
        n_err++; $display("FAIL loop_jmp it=%0d: got %h expected %h", it, {obs_load, rom_addr}, {1'b1, 4'h0});
      end
    end
  endtask

  task automatic test_in_undef();
    logic [3:0] out_before;
    exec(8'h20, 4'hA);
    n_vec++;
    if (reg_a !== 4'hA) begin
      n_err++; $display("FAIL in_a: got %h expected %h", reg_a, 4'hA);
    end
    exec(8'h7F, 4'h3);
    exec(8'h51, 4'h3);
    out_before = m_out;
    exec({4'h8, 4'($urandom_range(0, 15))}, 4'($urandom_range(0, 15)));
    n_vec++;
    if ({reg_a, reg_b, out_port, carry} !== {4'hA, 4'h0, out_before, 1'b0}) begin
      n_err++; $display("FAIL undef_nop: got %h expected %h",
                        {reg_a, reg_b, out_port, carry}, {4'hA, 4'h0, out_before, 1'b0});
    end
    n_vec++;
    if (obs_load !== 1'b0) begin
      n_err++; $display("FAIL undef_load: got %b expected %b", obs_load, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [7:0] ins;
    for (int n = 0; n < 400; n++) begin
      ins = 8'($urandom_range(0, 255));
      // Bias toward ADD and JNC so carries and conditional jumps are frequent
      if ($urandom_range(0, 2) == 0) ins[7:4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hE;
      exec(ins, 4'($urandom_range(0, 15)));
      n_vec++;
      if ({obs_load, obs_data, obs_addr} !== {exp_load, exp_data, exp_addr}) begin
        n_err++; $display("FAIL rand_comb n=%0d ins=%h: got %h expected %h", n, ins,
                          {obs_load, obs_data, obs_addr}, {exp_load, exp_data, exp_addr});
      end
      n_vec++;
      if ({reg_a, reg_b, out_port, carry} !== {m_a, m_b, m_out, m_c}) begin
        n_err++; $display("FAIL rand_regs n=%0d ins=%h: got %h expected %h", n, ins,
                          {reg_a, reg_b, out_port, carry}, {m_a, m_b, m_out, m_c});
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b0;
    instr   = 8'h80;
    in_port = 4'h0;
    model_reset();
    test_reset();
    test_alu();
    test_jnc_not_taken();
    test_jnc_taken();
    test_loop();
    test_in_undef();
    pulse_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/td4_exec.md
Name: td4_exec

Overview:
- Execute stage of the TD4 4-bit CPU. Sits directly downstream of the program counter.
- Takes the counter's `q` value as `pc`, receives the 8-bit instruction that instruction ROM returns for that address, and executes it in one clock.
- Holds registers A, B, OUT and carry flag C.
- Drives `pc_load`/`pc_data` back into the counter's `load`/`d` inputs for jumps.

Parameters:
- OUT_RESET, 4'b0000, value of the OUT register after reset.

Ports:
- clk       input   1  system clock; all state updates on rising edge
- reset     input   1  asynchronous, active-low reset
- pc        input   4  current counter value; drives `rom_addr`
- rom_addr  output  4  instruction ROM address; equals `pc`, combinational
- instr     input   8  instruction from ROM; [7:4] opcode, [3:0] immediate Im
- in_port   input   4  external input switches
- out_port  output  4  OUT register
- pc_load   output  1  to counter `load`; combinational
- pc_data   output  4  to counter `d`; equals Im, combinational
- reg_a     output  4  A register, for debug/observation
- reg_b     output  4  B register, for debug/observation
- carry     output  1  C flag

Behaviour:
- Reset (`reset`=0, asynchronous, independent of clk):
  - A=0, B=0, C=0, OUT=OUT_RESET.
  - `pc_load` forced 0 while reset is low.
  - Release of reset is synchronous to the next rising edge; the first instruction executes on the first edge with `reset`=1.
- One instruction per clock. No pipeline.
  - `instr` is combinational from `pc` within the same cycle.
  - Results become visible on the rising edge that also advances or loads the counter.
- Datapath: a single 4-bit adder computes `sum = src + Im` with a 5-bit result. `src` is selected by opcode. Writeback uses sum[3:0].
- Carry update: C <= sum[4] on every edge, for every opcode. MOV/IN/OUT/JMP/JNC/undefined use Im or 0 such that no carry can occur, so they clear C.
- Opcode table (Im = instr[3:0]):
  - 0000 ADD A,Im: A <= A+Im
  - 0101 ADD B,Im: B <= B+Im
  - 0011 MOV A,Im: A <= Im
  - 0111 MOV B,Im: B <= Im
  - 0001 MOV A,B: A <= B
  - 0100 MOV B,A: B <= A
  - 0010 IN A: A <= in_port
  - 0110 IN B: B <= in_port
  - 1001 OUT B: OUT <= B
  - 1011 OUT Im: OUT <= Im
  - 1111 JMP Im: `pc_load`=1
  - 1110 JNC Im: `pc_load` = ~C, using C as it was before this edge
  - All other opcodes: NOP. A, B, OUT unchanged; C <= 0; `pc_load`=0.
- Register rules:
  - MOV/IN/ADD sources: src is 0 for MOV Im, and the register value (A, B or in_port) for MOV reg and IN; Im term is 0 for those.
  - Add wraps modulo 16; the overflow bit goes only to C.
- Jump timing: `pc_load` and `pc_data` are valid combinationally in the jump's cycle. The counter loads Im on that edge, so the next cycle fetches from address Im.
- JNC after ADD: C sampled is the carry from the immediately preceding instruction. Any intervening non-ADD instruction clears it.
- `in_port` is sampled only on the IN edge. No synchronizer is included; the bench drives it synchronously.
- Reset asserted mid-program clears all state immediately, even between edges. The counter is reset by the same net.

Test Plan:
- Reset: drive `reset`=0 while A=5, B=3, OUT=9, C=1 -> all four read 0 before the next clk edge; `pc_load`=0.
- Immediate and ALU: MOV A,3 (0x33), ADD A,4 (0x04), MOV B,A (0x40), OUT B (0x90) -> A=7, B=7, out_port=7, C=0 after four edges.
- Carry and JNC not taken: A=0xF, ADD A,1 (0x01) -> A=0, C=1. Then JNC 5 (0xE5) -> `pc_load`=0 and C becomes 0.
- JNC taken: with C=0, instr 0xE5 -> `pc_load`=1, `pc_data`=5, and the next `rom_addr` is 5.
- JMP and loop: program at 0: ADD B,1 (0x51); OUT B (0x90); JMP 0 (0xF0); 16 iterations -> out_port counts 1..15 then 0. C=1 only on the ADD where B wraps 15->0, and C is cleared by the following OUT.
- IN and undefined opcode: in_port=0xA, IN A (0x20) -> A=0xA. Opcode 0x8x -> A, B, OUT unchanged, C=0, `pc_load`=0.
